pipe_scroller: RTL and testbench
================================

# pipe_scroller

Game-side driver for the two scrolling pipes. It sits between the game tick and the pipe pattern generator. It holds the horizontal positions of pipe 1 and pipe 2 and publishes them on PipesPosition1/2 for the pattern generator, which advances its index while a position reads 0. On each wrap it latches the generator's Pattern1/Pattern2 as the new gap height, counts pipes passed by the bird, and runs the IDLE/RUN/OVER game flow.

## Interface
Parameters:
- SCREEN_W, 640: right-edge start position of pipe 1.
- PIPE_SPACING, 320: fixed horizontal distance between pipe 1 and pipe 2.
- STEP, 1: pixels moved per Tick. Must divide SCREEN_W, PIPE_SPACING and BIRD_X.
- BIRD_X, 160: bird column used for scoring.
- GAP_INIT, 100: gap height loaded on reset or restart.

Ports:
- Clk, in, 1: system clock.
- Reset, in, 1: synchronous, active-low; clock Clk.
- Tick, in, 1: one-Clk-cycle pulse per scroll step.
- Start, in, 1: debounced, active-high, one-cycle start/restart request.
- Collision, in, 1: active-high collision flag from the bird/pipe checker.
- Pattern1, in, 16: next gap height for pipe 1.
- Pattern2, in, 16: next gap height for pipe 2.
- PipesPosition1, out, 16: registered x position of pipe 1.
- PipesPosition2, out, 16: registered x position of pipe 2.
- Gap1, out, 16: registered current gap height of pipe 1.
- Gap2, out, 16: registered current gap height of pipe 2.
- Score, out, 10: pipes passed; saturates at 999.
- Running, out, 1: high when state is RUN.
- GameOver, out, 1: high when state is OVER.

## Operation
States: IDLE=0, RUN=1, OVER=2. Encoding 3 is unreachable; if entered, go to IDLE with init values.

Init values (applied on reset and on restart):
- PipesPosition1 = SCREEN_W.
- PipesPosition2 = SCREEN_W + PIPE_SPACING.
- Gap1 = Gap2 = GAP_INIT.
- Score = 0.

Reset:
- Reset=0 at a Clk edge: state IDLE, all init values, Running=0, GameOver=0.
- Overrides every other input, including mid-RUN.

IDLE:
- Positions, gaps and score hold; Tick is ignored.
- Start=1: go to RUN.

RUN, on each Clk edge with Tick=1 and Collision=0, for each pipe n independently:
- If PipesPositionN == 0: PipesPositionN becomes 2*PIPE_SPACING − STEP, and GapN latches PatternN sampled that same cycle. This is the wrap.
- Otherwise PipesPositionN decrements by STEP.
- Score increments by 1 (saturating at 999) when a pipe's pre-step position equals BIRD_X.
- The pipes never hit BIRD_X on the same Tick, so Score changes by at most 1 per Tick.

Positions stay multiples of STEP, so each pipe holds 0 for exactly one Tick period. That is the window in which the generator advances.

RUN, transitions:
- Collision=1: go to OVER at the next edge. Any Tick in that cycle is ignored and positions freeze.
- Collision wins over a simultaneous Tick or Start.
- Start during RUN is ignored.

OVER:
- Positions, gaps and score hold; Collision and Tick are ignored.
- Start=1: load init values and go to IDLE.

Arithmetic: 16-bit unsigned positions. No underflow, because 0 is always caught as the wrap case.

## Timing
- All outputs are registered and change only on a Clk edge.
- Tick-to-position latency is 1 Clk: the new value is visible the cycle after Tick.
- Running and GameOver follow state with no extra delay.
- Pattern1/2 are sampled only on the wrap edge. The generator must hold stable values for that cycle.
- Pipe spacing is invariant: after the first Tick, PipesPosition2 − PipesPosition1 ≡ PIPE_SPACING mod 2*PIPE_SPACING, for all time in RUN.
- Start and Collision are level-sampled each Clk. A pulse must last at least 1 Clk.

## Test plan
- Reset, then Start, then 640 Ticks:
  - PipesPosition1 = 0, PipesPosition2 = 320.
  - Next Tick with Pattern1=140: PipesPosition1 = 639, Gap1 = 140, PipesPosition2 = 319.
- From reset, 480 Ticks in RUN:
  - Score = 1 after the Tick where PipesPosition1 leaves 160 (Tick 481 sees pre-step value 160; check Score=1 the cycle after).
  - Score = 2 exactly 320 Ticks later.
- Collision asserted in the same cycle as Tick and Start during RUN:
  - Next cycle state is OVER, GameOver=1, positions unchanged.
  - Further Ticks cause no change.
- In OVER, pulse Start:
  - Next cycle state is IDLE, positions 640/960, Gap1 = Gap2 = 100, Score = 0.
- Assert Reset=0 mid-RUN with PipesPosition1 = 37:
  - Next cycle positions are 640/960 and state IDLE.
  - Ticks while in IDLE leave positions unchanged.
- Force Score to 999 (run long or preload via bench):
  - Further pipe passes leave Score at 999.

Source files
------------

// File: rtl/pipe_scroller.sv
// Scrolls two pipes across the screen, latches new gap heights on wrap,
// counts pipes passed by the bird and runs the IDLE/RUN/OVER game flow.
module pipe_scroller #(
    parameter int unsigned SCREEN_W     = 640,
    parameter int unsigned PIPE_SPACING = 320,
    parameter int unsigned STEP         = 1,
    parameter int unsigned BIRD_X       = 160,
    parameter int unsigned GAP_INIT     = 100
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Tick,
    input  logic        Start,
    input  logic        Collision,
    input  logic [15:0] Pattern1,
    input  logic [15:0] Pattern2,
    output logic [15:0] PipesPosition1,
    output logic [15:0] PipesPosition2,
    output logic [15:0] Gap1,
    output logic [15:0] Gap2,
    output logic [9:0]  Score,
    output logic        Running,
    output logic        GameOver
);

    localparam int unsigned POS_W   = 16;
    localparam int unsigned SCORE_W = 10;

    localparam logic [POS_W-1:0]   POS1_INIT = POS_W'(SCREEN_W);
    localparam logic [POS_W-1:0]   POS2_INIT = POS_W'(SCREEN_W + PIPE_SPACING);
    localparam logic [POS_W-1:0]   WRAP_POS  = POS_W'(2 * PIPE_SPACING - STEP);
    localparam logic [POS_W-1:0]   STEP_W    = POS_W'(STEP);
    localparam logic [POS_W-1:0]   BIRD_W    = POS_W'(BIRD_X);
    localparam logic [POS_W-1:0]   GAP_W     = POS_W'(GAP_INIT);
    localparam logic [SCORE_W-1:0] SCORE_MAX = SCORE_W'(999);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OVER = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [POS_W-1:0]   pos1_q, pos1_d, pos2_q, pos2_d;
    logic [POS_W-1:0]   gap1_q, gap1_d, gap2_q, gap2_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic               running_q, running_d, over_q, over_d;

    // A pipe sitting at 0 wraps instead of stepping, so no underflow occurs.
    function automatic logic [POS_W-1:0] step_pos(input logic [POS_W-1:0] p);
        return (p == '0) ? WRAP_POS : p - STEP_W;
    endfunction

    always_comb begin
        state_d = state_q;
        pos1_d  = pos1_q;
        pos2_d  = pos2_q;
        gap1_d  = gap1_q;
        gap2_d  = gap2_q;
        score_d = score_q;

        case (state_q)
            IDLE: begin
                if (Start) state_d = RUN;
            end
            RUN: begin
                // Collision freezes the pipes and takes priority over Tick/Start.
                if (Collision) begin
                    state_d = OVER;
                end else if (Tick) begin
                    pos1_d = step_pos(pos1_q);
                    pos2_d = step_pos(pos2_q);
                    if (pos1_q == '0) gap1_d = Pattern1;
                    if (pos2_q == '0) gap2_d = Pattern2;
                    if ((pos1_q == BIRD_W || pos2_q == BIRD_W) && score_q != SCORE_MAX)
                        score_d = score_q + SCORE_W'(1);
                end
            end
            OVER: begin
                if (Start) begin
                    state_d = IDLE;
                    pos1_d  = POS1_INIT;
                    pos2_d  = POS2_INIT;
                    gap1_d  = GAP_W;
                    gap2_d  = GAP_W;
                    score_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                pos1_d  = POS1_INIT;
                pos2_d  = POS2_INIT;
                gap1_d  = GAP_W;
                gap2_d  = GAP_W;
                score_d = '0;
            end
        endcase

        running_d = (state_d == RUN);
        over_d    = (state_d == OVER);
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q   <= IDLE;
            pos1_q    <= POS1_INIT;
            pos2_q    <= POS2_INIT;
            gap1_q    <= GAP_W;
            gap2_q    <= GAP_W;
            score_q   <= '0;
            running_q <= 1'b0;
            over_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pos1_q    <= pos1_d;
            pos2_q    <= pos2_d;
            gap1_q    <= gap1_d;
            gap2_q    <= gap2_d;
            score_q   <= score_d;
            running_q <= running_d;
            over_q    <= over_d;
        end
    end

    assign PipesPosition1 = pos1_q;
    assign PipesPosition2 = pos2_q;
    assign Gap1           = gap1_q;
    assign Gap2           = gap2_q;
    assign Score          = score_q;
    assign Running        = running_q;
    assign GameOver       = over_q;

endmodule

// File: tb/tb_pipe_scroller.sv
// Bench for pipe_scroller: vector table for the main game flow, plus a
// small-geometry instance that scores every Tick to reach saturation quickly.
module tb_pipe_scroller;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Tick, Start, Collision;
    logic [15:0] Pattern1, Pattern2;
    logic [15:0] PipesPosition1, PipesPosition2, Gap1, Gap2;
    logic [9:0]  Score;
    logic        Running, GameOver;

    logic        s_tick, s_start;
    logic [15:0] s_pos1, s_pos2, s_gap1, s_gap2;
    logic [9:0]  s_score;
    logic        s_running, s_over;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 Clk = ~Clk;

    pipe_scroller dut (
        .Clk(Clk), .Reset(Reset), .Tick(Tick), .Start(Start), .Collision(Collision),
        .Pattern1(Pattern1), .Pattern2(Pattern2),
        .PipesPosition1(PipesPosition1), .PipesPosition2(PipesPosition2),
        .Gap1(Gap1), .Gap2(Gap2), .Score(Score), .Running(Running), .GameOver(GameOver)
    );

    pipe_scroller #(.SCREEN_W(8), .PIPE_SPACING(4), .STEP(4), .BIRD_X(4), .GAP_INIT(7)) dut_small (
        .Clk(Clk), .Reset(Reset), .Tick(s_tick), .Start(s_start), .Collision(1'b0),
        .Pattern1(16'd0), .Pattern2(16'd0),
        .PipesPosition1(s_pos1), .PipesPosition2(s_pos2),
        .Gap1(s_gap1), .Gap2(s_gap2), .Score(s_score), .Running(s_running), .GameOver(s_over)
    );

    typedef struct {
        int          reps;
        logic        rst_n, tick, start, coll;
        logic [15:0] p1, p2;
        logic [15:0] e_pos1, e_pos2, e_gap1, e_gap2;
        logic [9:0]  e_score;
        logic        e_run, e_over;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs[NV];

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL vec%0d %s: got %0d expected %0d", idx, name, act, exp);
        end
    endtask

    initial begin
        Reset = 1'b0; Tick = 1'b0; Start = 1'b0; Collision = 1'b0;
        Pattern1 = 16'd0; Pattern2 = 16'd0;
        s_tick = 1'b0; s_start = 1'b0;

        //          reps rst tk st co  p1   p2    pos1 pos2 gap1 gap2 sc run ovr
        vecs[0]  = '{2,   0, 0, 0, 0, 0,   0,    640, 960, 100, 100, 0, 0, 0};
        vecs[1]  = '{5,   1, 1, 0, 0, 0,   0,    640, 960, 100, 100, 0, 0, 0};
        vecs[2]  = '{1,   1, 0, 1, 0, 0,   0,    640, 960, 100, 100, 0, 1, 0};
        vecs[3]  = '{480, 1, 1, 0, 0, 0,   0,    160, 480, 100, 100, 0, 1, 0};
        vecs[4]  = '{1,   1, 1, 0, 0, 0,   0,    159, 479, 100, 100, 1, 1, 0};
        vecs[5]  = '{159, 1, 1, 0, 0, 0,   0,    0,   320, 100, 100, 1, 1, 0};
        vecs[6]  = '{1,   1, 1, 0, 0, 140, 77,   639, 319, 140, 100, 1, 1, 0};
        vecs[7]  = '{159, 1, 1, 0, 0, 0,   0,    480, 160, 140, 100, 1, 1, 0};
        vecs[8]  = '{1,   1, 1, 0, 0, 0,   0,    479, 159, 140, 100, 2, 1, 0};
        vecs[9]  = '{159, 1, 1, 0, 0, 0,   0,    320, 0,   140, 100, 2, 1, 0};
        vecs[10] = '{1,   1, 1, 0, 0, 1,   55,   319, 639, 140, 55,  2, 1, 0};
        vecs[11] = '{1,   1, 1, 1, 1, 0,   0,    319, 639, 140, 55,  2, 0, 1};
        vecs[12] = '{10,  1, 1, 0, 1, 0,   0,    319, 639, 140, 55,  2, 0, 1};
        vecs[13] = '{1,   1, 0, 1, 0, 0,   0,    640, 960, 100, 100, 0, 0, 0};
        vecs[14] = '{1,   1, 0, 1, 0, 0,   0,    640, 960, 100, 100, 0, 1, 0};
        vecs[15] = '{603, 1, 1, 0, 0, 0,   0,    37,  357, 100, 100, 1, 1, 0};
        vecs[16] = '{1,   0, 1, 0, 0, 0,   0,    640, 960, 100, 100, 0, 0, 0};
        vecs[17] = '{3,   1, 1, 0, 0, 0,   0,    640, 960, 100, 100, 0, 0, 0};

        @(negedge Clk);
        for (int i = 0; i < NV; i++) begin
            Reset = vecs[i].rst_n; Tick = vecs[i].tick; Start = vecs[i].start;
            Collision = vecs[i].coll; Pattern1 = vecs[i].p1; Pattern2 = vecs[i].p2;
            repeat (vecs[i].reps) @(negedge Clk);
            chk("pos1",     i, 32'(PipesPosition1), 32'(vecs[i].e_pos1));
            chk("pos2",     i, 32'(PipesPosition2), 32'(vecs[i].e_pos2));
            chk("gap1",     i, 32'(Gap1),           32'(vecs[i].e_gap1));
            chk("gap2",     i, 32'(Gap2),           32'(vecs[i].e_gap2));
            chk("score",    i, 32'(Score),          32'(vecs[i].e_score));
            chk("running",  i, 32'(Running),        32'(vecs[i].e_run));
            chk("gameover", i, 32'(GameOver),       32'(vecs[i].e_over));
        end
        Tick = 1'b0; Start = 1'b0; Collision = 1'b0;

        // Small geometry: after Tick k (k >= 2) the score is k-1 until it saturates.
        Reset = 1'b0;
        @(negedge Clk);
        Reset = 1'b1; s_start = 1'b1;
        @(negedge Clk);
        s_start = 1'b0;
        chk("sat_running", 100, 32'(s_running), 32'd1);
        s_tick = 1'b1;
        repeat (990) @(negedge Clk);
        chk("sat_pre", 101, 32'(s_score), 32'd989);
        repeat (10) @(negedge Clk);
        chk("sat_hit", 102, 32'(s_score), 32'd999);
        repeat (20) @(negedge Clk);
        chk("sat_hold", 103, 32'(s_score), 32'd999);
        s_tick = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
